// File: rtl/scan_driver.sv
// Scan-chain test driver: streams pattern bytes into a scan chain through a
// double buffer, pulses capture between patterns and returns response bytes.
module scan_driver #(
  parameter int CHAIN_LEN = 32
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] num_pat,
  input  logic [7:0] pat_data,
  input  logic       pat_valid,
  output logic       pat_ready,
  output logic       se,
  output logic       si,
  input  logic       so,
  output logic [7:0] resp_data,
  output logic       resp_valid,
  output logic       busy,
  output logic       done,
  output logic       err
);

  localparam int BYTES  = CHAIN_LEN / 8;
  localparam int BYTE_W = (BYTES > 1) ? $clog2(BYTES) : 1;
  localparam int BIT_W  = $clog2(CHAIN_LEN);
  localparam logic [BYTE_W-1:0] LAST_BYTE = BYTE_W'(BYTES - 1);
  localparam logic [BIT_W-1:0]  LAST_BIT  = BIT_W'(CHAIN_LEN - 1);

  typedef enum logic [2:0] {
    IDLE, PREFILL, SHIFT, CAPTURE, UNLOAD, DONE
  } state_t;

  state_t state, state_next;

  logic [1:0][CHAIN_LEN-1:0] pat_buf;
  logic [1:0]                buf_full;
  logic                      act_sel;
  logic                      fill_sel;
  logic [BYTE_W-1:0]         fill_cnt;
  logic [7:0]                num_pat_q;
  logic [7:0]                fetched;
  logic [7:0]                shifted;
  logic [BIT_W-1:0]          bit_cnt;
  logic                      first_shift;
  logic [7:0]                resp_sr;

  logic se_next, si_next;
  logic accept, fill_last, more_pat, swap, underrun, collect;

  assign pat_ready = (state == PREFILL || state == SHIFT || state == CAPTURE) &&
                     !buf_full[fill_sel] && (fetched < num_pat_q);
  assign accept    = pat_valid && pat_ready;
  assign fill_last = accept && (fill_cnt == LAST_BYTE);
  assign more_pat  = ({1'b0, shifted} + 9'd1) < {1'b0, num_pat_q};
  assign collect   = (state == SHIFT && !first_shift) || state == UNLOAD;
  assign busy      = (state != IDLE);
  assign done      = (state == DONE);

  // se/si are registered, so the next-state logic also picks the bit that
  // must be on si during the upcoming cycle.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can
    // leave a value held over, which would infer a latch.
    state_next = state;
    se_next    = 1'b0;
    si_next    = 1'b0;
    swap       = 1'b0;
    underrun   = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_next = (num_pat == 8'd0) ? DONE : PREFILL;
      end
      PREFILL: begin
        if (fill_last) begin
          state_next = SHIFT;
          se_next    = 1'b1;
          // With a one-byte chain the completing byte carries bit 0.
          si_next    = (fill_cnt == '0) ? pat_data[0] : pat_buf[act_sel][0];
        end
      end
      SHIFT: begin
        if (bit_cnt == LAST_BIT) begin
          state_next = CAPTURE;
        end else begin
          se_next = 1'b1;
          si_next = pat_buf[act_sel][bit_cnt + 1'b1];
        end
      end
      CAPTURE: begin
        if (!more_pat) begin
          state_next = UNLOAD;
          se_next    = 1'b1;
        end else if (buf_full[~act_sel]) begin
          state_next = SHIFT;
          se_next    = 1'b1;
          si_next    = pat_buf[~act_sel][0];
          swap       = 1'b1;
        end else begin
          state_next = DONE;
          underrun   = 1'b1;
        end
      end
      UNLOAD: begin
        if (bit_cnt == LAST_BIT) state_next = DONE;
        else                     se_next    = 1'b1;
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      se          <= 1'b0;
      si          <= 1'b0;
      resp_valid  <= 1'b0;
      resp_data   <= 8'h00;
      resp_sr     <= 8'h00;
      err         <= 1'b0;
      buf_full    <= 2'b00;
      act_sel     <= 1'b0;
      fill_sel    <= 1'b0;
      fill_cnt    <= '0;
      num_pat_q   <= 8'd0;
      fetched     <= 8'd0;
      shifted     <= 8'd0;
      bit_cnt     <= '0;
      first_shift <= 1'b0;
    end else begin
      state      <= state_next;
      se         <= se_next;
      si         <= si_next;
      resp_valid <= 1'b0;

      if (state == IDLE && start) begin
        err         <= 1'b0;
        num_pat_q   <= num_pat;
        fetched     <= 8'd0;
        shifted     <= 8'd0;
        buf_full    <= 2'b00;
        act_sel     <= 1'b0;
        fill_sel    <= 1'b0;
        fill_cnt    <= '0;
        bit_cnt     <= '0;
        first_shift <= 1'b1;
      end

      if (accept) begin
        if (fill_last) begin
          buf_full[fill_sel] <= 1'b1;
          fill_sel           <= ~fill_sel;
          fill_cnt           <= '0;
          fetched            <= fetched + 8'd1;
        end else begin
          fill_cnt <= fill_cnt + 1'b1;
        end
      end

      if (state == SHIFT || state == UNLOAD)
        bit_cnt <= (bit_cnt == LAST_BIT) ? '0 : bit_cnt + 1'b1;

      if (state == CAPTURE) begin
        shifted     <= shifted + 8'd1;
        first_shift <= 1'b0;
      end

      if (swap) begin
        buf_full[act_sel] <= 1'b0;
        act_sel           <= ~act_sel;
      end

      if (underrun) err <= 1'b1;

      // Partially filled buffers never survive past the end of a session.
      if (state == DONE) begin
        buf_full <= 2'b00;
        fill_cnt <= '0;
      end

      if (collect) begin
        resp_sr <= {so, resp_sr[7:1]};
        if (bit_cnt[2:0] == 3'b111) begin
          resp_data  <= {so, resp_sr[7:1]};
          resp_valid <= 1'b1;
        end
      end
    end
  end

  // NOTE: pattern storage has no reset; the full flags alone decide whether
  // its contents are meaningful, so a reset only needs to clear those.
  always_ff @(posedge clk) begin
    if (accept) pat_buf[fill_sel][{fill_cnt, 3'b000} +: 8] <= pat_data;
  end

endmodule

// File: tb/tb_scan_driver.sv
// Self-checking bench for scan_driver with a 16-bit chain model that
// complements its contents on every capture.
module tb_scan_driver;

  localparam int CL = 16;
  localparam int BPP = CL / 8;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       start = 1'b0;
  logic [7:0] num_pat = 8'd0;
  logic [7:0] pat_data = 8'd0;
  logic       pat_valid = 1'b0;
  logic       pat_ready, se, si, so, resp_valid, busy, done, err;
  logic [7:0] resp_data;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  scan_driver #(.CHAIN_LEN(CL)) dut (
    .clk(clk), .reset(reset), .start(start), .num_pat(num_pat),
    .pat_data(pat_data), .pat_valid(pat_valid), .pat_ready(pat_ready),
    .se(se), .si(si), .so(so), .resp_data(resp_data), .resp_valid(resp_valid),
    .busy(busy), .done(done), .err(err)
  );

  // Chain model: shifts while se=1, captures ~contents on the first se=0 edge.
  logic [CL-1:0] chain = '0;
  logic          prev_se = 1'b0;
  assign so = chain[CL-1];
  always @(posedge clk) begin
    if (se)           chain <= {chain[CL-2:0], si};
    else if (prev_se) chain <= ~chain;
    prev_se <= se;
  end

  logic [7:0] src[$];
  logic [7:0] got[$];
  logic [7:0] exp_q[$];
  int  src_idx, se_cnt, se_low, ready_cnt, done_cyc;
  logic err_at_done, err_first;
  bit  aborted;

  // Each pattern comes back complemented, one pattern later, in byte order.
  task automatic build_expected();
    exp_q.delete();
    foreach (src[i]) exp_q.push_back(~src[i]);
  endtask

  task automatic fill_random(input int nbytes);
    src.delete();
    for (int i = 0; i < nbytes; i++) src.push_back(8'($urandom));
  endtask

  task automatic run_session(input int n, input int withhold, input bit busy_start,
                             input bit abort);
    got.delete();
    src_idx = 0; se_cnt = 0; se_low = 0; ready_cnt = 0; done_cyc = -1;
    err_at_done = 1'b0; err_first = 1'bx; aborted = 1'b0;
    @(negedge clk);
    start = 1'b1; num_pat = 8'(n); pat_valid = 1'b0;
    for (int cyc = 1; cyc <= 2000; cyc++) begin
      @(negedge clk);
      start   = busy_start && (cyc == 20);
      num_pat = 8'(7);
      if (cyc == 1) err_first = err;
      if (resp_valid) got.push_back(resp_data);
      if (se) se_cnt++;
      else if (busy && se_cnt > 0 && !done) se_low++;
      if (pat_ready) ready_cnt++;
      if (abort && se_cnt == 5) begin
        reset = 1'b0;
        aborted = 1'b1;
        break;
      end
      if (done) begin
        done_cyc = cyc;
        err_at_done = err;
        break;
      end
      pat_valid = (src_idx < src.size()) && (src_idx < withhold);
      pat_data  = pat_valid ? src[src_idx] : 8'($urandom);
      if (pat_valid && pat_ready) src_idx++;
    end
    pat_valid = 1'b0;
    start = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({se, si, pat_ready, resp_valid, busy, done, err, resp_data} !== 15'd0) begin
      errors++;
      $display("FAIL reset_outputs: got %b, want all zero",
               {se, si, pat_ready, resp_valid, busy, done, err, resp_data});
    end
    reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_single();
    src = '{8'hA5, 8'h3C};
    run_session(1, 1000, 1'b0, 1'b0);
    checks++;
    if (done_cyc < 0) begin errors++; $display("FAIL single_done: no done within budget"); end
    checks++;
    if (se_cnt !== 32) begin errors++; $display("FAIL single_se: got %0d se cycles, want 32", se_cnt); end
    checks++;
    if (se_low !== 1) begin errors++; $display("FAIL single_capture: got %0d, want 1", se_low); end
    checks++;
    if (got.size() !== 2) begin
      errors++; $display("FAIL single_count: got %0d bytes, want 2", got.size());
    end else begin
      checks++;
      if (got[0] !== 8'h5A || got[1] !== 8'hC3) begin
        errors++; $display("FAIL single_bytes: got %h %h, want 5a c3", got[0], got[1]);
      end
    end
  endtask

  task automatic test_two();
    logic [7:0] want[4];
    want = '{8'hFF, 8'hFF, 8'h00, 8'hF0};
    src = '{8'h00, 8'h00, 8'hFF, 8'h0F};
    run_session(2, 1000, 1'b0, 1'b0);
    checks++;
    if (got.size() !== 4) begin
      errors++; $display("FAIL two_count: got %0d strobes, want 4", got.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (got[i] !== want[i]) begin
          errors++; $display("FAIL two_byte%0d: got %h, want %h", i, got[i], want[i]);
        end
      end
    end
    checks++;
    if (se_low !== 2) begin errors++; $display("FAIL two_capture: got %0d se-low cycles, want 2", se_low); end
    checks++;
    if (err_at_done !== 1'b0) begin errors++; $display("FAIL two_err: got %b, want 0", err_at_done); end
  endtask

  task automatic test_zero();
    src.delete();
    run_session(0, 1000, 1'b0, 1'b0);
    checks++;
    if (done_cyc !== 1) begin errors++; $display("FAIL zero_latency: got %0d, want 1", done_cyc); end
    checks++;
    if (se_cnt !== 0 || ready_cnt !== 0) begin
      errors++; $display("FAIL zero_quiet: se %0d ready %0d, want 0 0", se_cnt, ready_cnt);
    end
  endtask

  task automatic test_underrun();
    fill_random(4);
    run_session(2, 2, 1'b0, 1'b0);
    checks++;
    if (done_cyc < 0 || err_at_done !== 1'b1) begin
      errors++; $display("FAIL underrun_err: done_cyc %0d err %b, want done with err 1", done_cyc, err_at_done);
    end
    checks++;
    if (got.size() !== 0 || se_cnt !== 16) begin
      errors++; $display("FAIL underrun_stream: resp %0d se %0d, want 0 16", got.size(), se_cnt);
    end
    pat_valid = 1'b1;
    @(negedge clk);
    checks++;
    if ({err, busy, pat_ready} !== 3'b100) begin
      errors++; $display("FAIL underrun_idle: err/busy/ready %b, want 100", {err, busy, pat_ready});
    end
    pat_valid = 1'b0;
    fill_random(BPP);
    build_expected();
    run_session(1, 1000, 1'b0, 1'b0);
    checks++;
    if (err_first !== 1'b0 || err_at_done !== 1'b0) begin
      errors++; $display("FAIL underrun_clear: err %b/%b, want 0/0", err_first, err_at_done);
    end
    checks++;
    if (got !== exp_q) begin errors++; $display("FAIL underrun_next: got %p, want %p", got, exp_q); end
  endtask

  task automatic test_abort();
    fill_random(BPP);
    run_session(1, 1000, 1'b0, 1'b1);
    #1;
    checks++;
    if (!aborted || {se, si, pat_ready, resp_valid, busy, done, err, resp_data} !== 15'd0) begin
      errors++;
      $display("FAIL abort_outputs: aborted %b got %b, want all zero", aborted,
               {se, si, pat_ready, resp_valid, busy, done, err, resp_data});
    end
    repeat (2) @(negedge clk);
    reset = 1'b1;
    fill_random(BPP);
    build_expected();
    run_session(1, 1000, 1'b0, 1'b0);
    checks++;
    if (got !== exp_q || done_cyc < 0) begin
      errors++; $display("FAIL abort_fresh: got %p, want %p", got, exp_q);
    end
  endtask

  task automatic test_busy_start();
    fill_random(3 * BPP);
    build_expected();
    run_session(3, 1000, 1'b1, 1'b0);
    checks++;
    if (src_idx !== 3 * BPP) begin errors++; $display("FAIL busy_start_bytes: got %0d, want %0d", src_idx, 3 * BPP); end
    checks++;
    if (got !== exp_q) begin errors++; $display("FAIL busy_start_stream: got %p, want %p", got, exp_q); end
  endtask

  task automatic test_random();
    for (int s = 0; s < 6; s++) begin
      int n;
      n = $urandom_range(1, 5);
      fill_random(n * BPP);
      build_expected();
      run_session(n, 1000, 1'b0, 1'b0);
      checks++;
      if (got !== exp_q) begin
        errors++; $display("FAIL random%0d_stream: n %0d got %p, want %p", s, n, got, exp_q);
      end
      checks++;
      if (se_cnt !== (n + 1) * CL || se_low !== n || src_idx !== n * BPP) begin
        errors++;
        $display("FAIL random%0d_timing: se %0d low %0d bytes %0d, want %0d %0d %0d",
                 s, se_cnt, se_low, src_idx, (n + 1) * CL, n, n * BPP);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_two();
    test_zero();
    test_underrun();
    test_abort();
    test_busy_start();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
